// File: rtl/mips32_pipe_core.sv
// Five-stage pipelined MIPS32-subset core with an internal unified memory and register file.
// Hazards: EX/MEM and MEM/WB forwarding, one-cycle load-use stall, branches resolved in EX.
module mips32_pipe_core #(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        halted,
  output logic [31:0] pc
);

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0A;
  localparam logic [5:0] OP_SUBI  = 6'h0B;
  localparam logic [5:0] OP_SLTI  = 6'h0C;
  localparam logic [5:0] OP_BNEQZ = 6'h0D;
  localparam logic [5:0] OP_BEQZ  = 6'h0E;
  localparam logic [5:0] OP_HLT   = 6'h3F;
  // Opcode 0x3E is not in the instruction set, so it serves as the bubble encoding.
  localparam logic [31:0] NOP_IR  = 32'hF800_0000;

  typedef enum logic [2:0] {
    K_NOP = 3'd0, K_RR = 3'd1, K_RI = 3'd2, K_LW = 3'd3,
    K_SW  = 3'd4, K_BR = 3'd5, K_HLT = 3'd6
  } kind_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } ifid_t;

  typedef struct packed {
    kind_t       kind;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        wr;
    logic [4:0]  dest;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] npc;
  } idex_t;

  typedef struct packed {
    kind_t       kind;
    logic        wr;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] b;
  } exmem_t;

  typedef struct packed {
    kind_t       kind;
    logic        wr;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] lmd;
  } memwb_t;

  function automatic kind_t kind_of(input logic [5:0] op);
    kind_t k;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: k = K_RR;
      OP_ADDI, OP_SUBI, OP_SLTI:                     k = K_RI;
      OP_LW:                                         k = K_LW;
      OP_SW:                                         k = K_SW;
      OP_BNEQZ, OP_BEQZ:                             k = K_BR;
      OP_HLT:                                        k = K_HLT;
      default:                                       k = K_NOP;
    endcase
    return k;
  endfunction

  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] Reg [0:31];

  ifid_t  ifid;
  idex_t  idex, id_dec;
  exmem_t exmem, ex_res;
  memwb_t memwb, mem_res;

  logic        taken_branch;
  logic        fetch_stop;
  logic [31:0] if_ir, pc_next;
  kind_t       id_kind;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_use_rs, id_use_rt, load_use;
  logic [31:0] ex_a, ex_b, ex_alu, ex_target;
  logic        ex_cond, ex_taken;
  logic [31:0] wb_data;
  logic        wb_wr;

  assign if_ir   = Mem[pc[ADDR_W-1:0]];
  assign pc_next = pc + 32'd1;

  assign wb_data = (memwb.kind == K_LW) ? memwb.lmd : memwb.alu;
  assign wb_wr   = memwb.wr && !halted;

  // Decode and register read; a same-cycle WB write to the source is bypassed in.
  always_comb begin
    id_dec    = '0;
    id_rs     = ifid.ir[25:21];
    id_rt     = ifid.ir[20:16];
    id_rd     = ifid.ir[15:11];
    id_kind   = kind_of(ifid.ir[31:26]);
    id_use_rs = id_kind inside {K_RR, K_RI, K_LW, K_SW, K_BR};
    id_use_rt = id_kind inside {K_RR, K_SW};
    id_dec.kind = id_kind;
    id_dec.op   = ifid.ir[31:26];
    id_dec.rs   = id_rs;
    id_dec.rt   = id_rt;
    id_dec.dest = (id_kind == K_RR) ? id_rd : id_rt;
    id_dec.wr   = (id_kind inside {K_RR, K_RI, K_LW}) && (id_dec.dest != 5'd0);
    id_dec.imm  = {{16{ifid.ir[15]}}, ifid.ir[15:0]};
    id_dec.npc  = ifid.npc;
    if (id_rs == 5'd0)                        id_dec.a = 32'd0;
    else if (wb_wr && memwb.dest == id_rs)    id_dec.a = wb_data;
    else                                      id_dec.a = Reg[id_rs];
    if (id_rt == 5'd0)                        id_dec.b = 32'd0;
    else if (wb_wr && memwb.dest == id_rt)    id_dec.b = wb_data;
    else                                      id_dec.b = Reg[id_rt];
    load_use = (idex.kind == K_LW) && idex.wr &&
               ((id_use_rs && id_rs == idex.dest) || (id_use_rt && id_rt == idex.dest));
  end

  // Operand forwarding: MEM/WB first, then the younger EX/MEM overrides it.
  always_comb begin
    ex_a = idex.a;
    ex_b = idex.b;
    if (memwb.wr && memwb.dest == idex.rs) ex_a = wb_data;
    if (memwb.wr && memwb.dest == idex.rt) ex_b = wb_data;
    if (exmem.wr && exmem.kind != K_LW && exmem.dest == idex.rs) ex_a = exmem.alu;
    if (exmem.wr && exmem.kind != K_LW && exmem.dest == idex.rt) ex_b = exmem.alu;
  end

  always_comb begin
    case (idex.op)
      OP_ADD:         ex_alu = ex_a + ex_b;
      OP_SUB:         ex_alu = ex_a - ex_b;
      OP_AND:         ex_alu = ex_a & ex_b;
      OP_OR:          ex_alu = ex_a | ex_b;
      OP_SLT:         ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
      OP_MUL:         ex_alu = ex_a * ex_b;
      OP_ADDI:        ex_alu = ex_a + idex.imm;
      OP_SUBI:        ex_alu = ex_a - idex.imm;
      OP_SLTI:        ex_alu = {31'd0, $signed(ex_a) < $signed(idex.imm)};
      OP_LW, OP_SW:   ex_alu = ex_a + idex.imm;
      default:        ex_alu = 32'd0;
    endcase
    ex_cond   = (idex.op == OP_BNEQZ) ? (ex_a != 32'd0) : (ex_a == 32'd0);
    // The slot right after a taken branch always holds a squashed bubble.
    ex_taken  = (idex.kind == K_BR) && ex_cond && !taken_branch;
    ex_target = idex.npc + idex.imm;
    ex_res    = '{kind: idex.kind, wr: idex.wr, dest: idex.dest, alu: ex_alu, b: ex_b};
    mem_res   = '{kind: exmem.kind, wr: exmem.wr, dest: exmem.dest, alu: exmem.alu,
                  lmd: Mem[exmem.alu[ADDR_W-1:0]]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc           <= 32'd0;
      halted       <= 1'b0;
      taken_branch <= 1'b0;
      fetch_stop   <= 1'b0;
      ifid         <= '{ir: NOP_IR, npc: 32'd0};
      idex         <= '0;
      exmem        <= '0;
      memwb        <= '0;
    end else if (!halted) begin
      taken_branch <= ex_taken;
      exmem        <= ex_res;
      memwb        <= mem_res;
      if (memwb.kind == K_HLT) halted <= 1'b1;
      if (ex_taken) begin
        pc   <= ex_target;
        ifid <= '{ir: NOP_IR, npc: 32'd0};
        idex <= '0;
      end else if (load_use) begin
        idex <= '0;
      end else if (fetch_stop || id_kind == K_HLT) begin
        // HLT has been decoded: stop fetching and let older instructions drain.
        fetch_stop <= 1'b1;
        ifid       <= '{ir: NOP_IR, npc: 32'd0};
        idex       <= id_dec;
      end else begin
        pc   <= pc_next;
        ifid <= '{ir: if_ir, npc: pc_next};
        idex <= id_dec;
      end
    end
  end

  // Register file and memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && wb_wr) Reg[memwb.dest] <= wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n && !halted && exmem.kind == K_SW) Mem[exmem.alu[ADDR_W-1:0]] <= exmem.b;
  end

endmodule

// File: tb/tb_mips32_pipe_core.sv
// Bench for mips32_pipe_core: directed program table, hand-written halt/reset sequences,
// and random programs compared against an instruction-level interpreter.
module tb_mips32_pipe_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halted;
  logic [31:0] pc;

  mips32_pipe_core #(.MEM_DEPTH(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] ADD = 6'h00, SUB = 6'h01, OR_ = 6'h03, SLT = 6'h04, MUL = 6'h05;
  localparam logic [5:0] LW = 6'h08, SW = 6'h09, ADDI = 6'h0A, SUBI = 6'h0B, SLTI = 6'h0C;
  localparam logic [5:0] BNEQZ = 6'h0D, BEQZ = 6'h0E, HLT = 6'h3F;
  localparam logic [31:0] HLT_W = 32'hFC00_0000;

  typedef struct {
    string name;
    int    p0;
    int    plen;
    int    e0;
    int    elen;
    int    exp_cyc;
  } vec_t;

  typedef struct {
    bit          is_mem;
    int          idx;
    logic [31:0] val;
  } exp_t;

  vec_t        vecs[$];
  exp_t        exps[$];
  logic [31:0] words[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [1024];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
    logic [4:0] d, s, t;
    d = 5'(rd); s = 5'(rs); t = 5'(rt);
    return {op, s, t, d, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
    logic [31:0] v;
    logic [4:0]  s, t;
    v = imm; s = 5'(rs); t = 5'(rt);
    return {op, s, t, v[15:0]};
  endfunction

  task automatic new_vec(input string name, input int exp_cyc);
    vec_t v;
    v.name = name; v.p0 = words.size(); v.plen = 0;
    v.e0 = exps.size(); v.elen = 0; v.exp_cyc = exp_cyc;
    vecs.push_back(v);
  endtask

  task automatic ins(input logic [31:0] w);
    int last;
    last = vecs.size() - 1;
    words.push_back(w);
    vecs[last].plen = vecs[last].plen + 1;
  endtask

  task automatic ex(input bit is_mem, input int idx, input logic [31:0] val);
    exp_t e;
    int   last;
    last = vecs.size() - 1;
    e.is_mem = is_mem; e.idx = idx; e.val = val;
    exps.push_back(e);
    vecs[last].elen = vecs[last].elen + 1;
  endtask

  task automatic put(input int addr, input logic [31:0] w);
    dut.Mem[addr] = w;
    m_mem[addr]   = w;
  endtask

  task automatic preload();
    for (int i = 0; i < 1024; i++) begin
      dut.Mem[i] = 32'd0;
      m_mem[i]   = 32'd0;
    end
    for (int k = 0; k < 32; k++) begin
      dut.Reg[k] = k;
      m_reg[k]   = k;
    end
    put(120, 32'd85);
    put(200, 32'd7);
    put(1023, 32'hDEAD_BEEF);
  endtask

  // Holds the core in reset while memories are (re)loaded.
  task automatic begin_test();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    preload();
  endtask

  task automatic run_dut(input int budget, output int cyc);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (!halted && cyc < budget) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("halt_within_budget", {31'd0, halted}, 32'd1);
  endtask

  task automatic put_vec(input int v);
    for (int j = 0; j < vecs[v].plen; j++) put(j, words[vecs[v].p0 + j]);
  endtask

  // Sequential instruction-set interpreter over m_reg/m_mem.
  task automatic iss_run();
    int          p;
    bit          done;
    logic [31:0] ir, a, b, imm, res;
    logic [5:0]  op;
    int          rs, rt, rd, np;
    p = 0;
    done = 0;
    for (int step = 0; step < 5000 && !done; step++) begin
      ir  = m_mem[p % 1024];
      op  = ir[31:26];
      rs  = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
      imm = {{16{ir[15]}}, ir[15:0]};
      a   = m_reg[rs]; b = m_reg[rt];
      np  = p + 1;
      case (op)
        6'h00: res = a + b;
        6'h01: res = a - b;
        6'h02: res = a & b;
        6'h03: res = a | b;
        6'h04: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h05: res = a * b;
        default: res = 32'd0;
      endcase
      if (op <= 6'h05) begin
        if (rd != 0) m_reg[rd] = res;
      end else if (op == ADDI) begin
        if (rt != 0) m_reg[rt] = a + imm;
      end else if (op == SUBI) begin
        if (rt != 0) m_reg[rt] = a - imm;
      end else if (op == SLTI) begin
        if (rt != 0) m_reg[rt] = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
      end else if (op == LW) begin
        if (rt != 0) m_reg[rt] = m_mem[(a + imm) % 1024];
      end else if (op == SW) begin
        m_mem[(a + imm) % 1024] = b;
      end else if (op == BNEQZ) begin
        if (a != 0) np = p + 1 + int'(imm);
      end else if (op == BEQZ) begin
        if (a == 0) np = p + 1 + int'(imm);
      end else if (op == HLT) begin
        done = 1;
      end
      p = np;
    end
  endtask

  task automatic gen_random_prog(input int len);
    int          sel, off;
    int          ra, rb, rc;
    logic [5:0]  op;
    logic [31:0] w;
    for (int i = 0; i < len; i++) begin
      ra = $urandom_range(0, 7); rb = $urandom_range(0, 7); rc = $urandom_range(0, 7);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: w = enc_r(6'($urandom_range(0, 5)), rc, ra, rb);
        4: begin
          case ($urandom_range(0, 2))
            0:       op = ADDI;
            1:       op = SUBI;
            default: op = SLTI;
          endcase
          w = enc_i(op, rc, ra, int'($urandom_range(0, 65535)));
        end
        5: w = enc_i(LW, rc, 0, 400 + int'($urandom_range(0, 15)));
        6: w = enc_i(SW, rb, 0, 400 + int'($urandom_range(0, 15)));
        7: begin
          off = $urandom_range(0, 3);
          if (off > len - 1 - i) off = len - 1 - i;
          w = enc_i(($urandom_range(0, 1) == 1) ? BNEQZ : BEQZ, 0, ra, off);
        end
        8: w = enc_i(6'($urandom_range(16, 31)), rc, ra, int'($urandom_range(0, 65535)));
        default: w = enc_i(ADDI, rc, ra, int'($urandom_range(0, 40)) - 20);
      endcase
      put(i, w);
    end
    put(len, HLT_W);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [31:0] v, act;

    // Directed program table: instructions, expected architectural state, halt cycle.
    new_vec("spec_prog", 12);
    ins(32'h28010078); ins(32'h0c631800); ins(32'h20220000); ins(32'h0c631800);
    ins(32'h2842002d); ins(32'h0c631800); ins(32'h24220001); ins(32'hfc000000);
    ex(0, 1, 120); ex(0, 2, 130); ex(1, 120, 85); ex(1, 121, 130);

    new_vec("back_to_back", 8);
    ins(enc_i(ADDI, 1, 0, 10)); ins(enc_r(ADD, 2, 1, 1)); ins(enc_r(SUB, 3, 2, 1)); ins(HLT_W);
    ex(0, 1, 10); ex(0, 2, 20); ex(0, 3, 10);

    new_vec("load_use", 9);
    ins(enc_i(ADDI, 1, 0, 200)); ins(enc_i(LW, 2, 1, 0)); ins(enc_i(ADDI, 3, 2, 1)); ins(HLT_W);
    ex(0, 2, 7); ex(0, 3, 8);

    new_vec("loop", 31);
    ins(enc_i(ADDI, 1, 0, 5)); ins(enc_i(ADDI, 2, 0, 1)); ins(enc_r(MUL, 2, 2, 1));
    ins(enc_i(SUBI, 1, 1, 1)); ins(enc_i(BNEQZ, 0, 1, -3)); ins(enc_i(ADDI, 9, 0, 1)); ins(HLT_W);
    ex(0, 1, 0); ex(0, 2, 120); ex(0, 9, 1);

    new_vec("branch_shadow", 8);
    ins(enc_i(BEQZ, 0, 0, 2)); ins(enc_i(ADDI, 5, 5, 100)); ins(enc_i(ADDI, 6, 6, 100)); ins(HLT_W);
    ex(0, 5, 5); ex(0, 6, 6);

    new_vec("not_taken", 7);
    ins(enc_i(BNEQZ, 0, 0, 5)); ins(enc_i(ADDI, 7, 0, 70)); ins(HLT_W);
    ex(0, 7, 70);

    new_vec("store_load", 8);
    ins(enc_i(ADDI, 1, 0, 300)); ins(enc_i(SW, 1, 1, 0)); ins(enc_i(LW, 8, 1, 0)); ins(HLT_W);
    ex(1, 300, 300); ex(0, 8, 300);

    new_vec("wb_bypass", 9);
    ins(enc_i(ADDI, 1, 0, 33)); ins(enc_r(OR_, 3, 3, 3)); ins(enc_r(OR_, 3, 3, 3));
    ins(enc_r(ADD, 4, 1, 1)); ins(HLT_W);
    ex(0, 4, 66);

    new_vec("misc_wrap_slt_r0", 14);
    ins(enc_i(ADDI, 0, 0, 5)); ins(enc_r(ADD, 14, 0, 0)); ins(enc_i(LW, 10, 0, -1));
    ins(enc_i(ADDI, 11, 0, -1)); ins(enc_r(SLT, 12, 11, 0)); ins(enc_i(SLTI, 13, 0, -1));
    ins(enc_r(SUB, 15, 0, 11)); ins(enc_r(MUL, 16, 11, 11)); ins(enc_i(6'h20, 17, 0, 16'h1234));
    ins(HLT_W);
    ex(0, 0, 0); ex(0, 14, 0); ex(0, 10, 32'hDEAD_BEEF); ex(0, 12, 1); ex(0, 13, 0);
    ex(0, 15, 1); ex(0, 16, 1); ex(0, 17, 17);

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pc", pc, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);

    for (int vi = 0; vi < vecs.size(); vi++) begin
      begin_test();
      put_vec(vi);
      run_dut(200, cyc);
      check({vecs[vi].name, "_cycles"}, cyc, vecs[vi].exp_cyc);
      for (int e = vecs[vi].e0; e < vecs[vi].e0 + vecs[vi].elen; e++) begin
        act = exps[e].is_mem ? dut.Mem[exps[e].idx] : dut.Reg[exps[e].idx];
        check($sformatf("%s_%s%0d", vecs[vi].name, exps[e].is_mem ? "mem" : "r", exps[e].idx),
              act, exps[e].val);
      end
    end

    // HLT followed by ADDI: nothing after HLT executes and the core freezes.
    begin_test();
    put(0, enc_i(ADDI, 4, 0, 44));
    put(1, HLT_W);
    put(2, enc_i(ADDI, 5, 0, 99));
    run_dut(50, cyc);
    check("hlt_cycles", cyc, 6);
    check("hlt_pc", pc, 32'd2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("hlt_pc_stable", pc, 32'd2);
    check("hlt_still_halted", {31'd0, halted}, 32'd1);
    check("hlt_r4", dut.Reg[4], 32'd44);
    check("hlt_r5_untouched", dut.Reg[5], 32'd5);

    // Reset in the middle of the loop program, then rerun it to completion.
    begin_test();
    put_vec(3);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_pc", pc, 32'd0);
    check("midreset_halted", {31'd0, halted}, 32'd0);
    check("midreset_r20_kept", dut.Reg[20], 32'd20);
    run_dut(200, cyc);
    check("midreset_rerun_cycles", cyc, 31);
    check("midreset_r2", dut.Reg[2], 32'd120);
    check("midreset_r9", dut.Reg[9], 32'd1);
    check("midreset_mem120_kept", dut.Mem[120], 32'd85);

    // Random programs against the interpreter.
    for (int t = 0; t < 25; t++) begin
      begin_test();
      for (int k = 1; k < 32; k++) begin
        v = $urandom;
        dut.Reg[k] = v;
        m_reg[k]   = v;
      end
      for (int a = 400; a < 416; a++) put(a, $urandom);
      gen_random_prog(20);
      iss_run();
      for (int k = 0; k < 32; k++) exp_q.push_back(m_reg[k]);
      for (int a = 400; a < 416; a++) exp_q.push_back(m_mem[a]);
      run_dut(300, cyc);
      for (int k = 0; k < 32; k++) check($sformatf("rand%0d_r%0d", t, k), dut.Reg[k], exp_q.pop_front());
      for (int a = 400; a < 416; a++) check($sformatf("rand%0d_mem%0d", t, a), dut.Mem[a], exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
